mux_scan: RTL
=============

# mux_scan

Registered, parametrised N-channel data selector with enable, manual-select and auto-scan modes. It extends the team's combinational 8:1 enable-gated multiplexer to W-bit channels, any channel count N and a clocked output. In auto-scan mode it steps through all channels with a programmable dwell time. It sits between multi-channel sources (switch banks, sensor lines) and single-channel consumers such as display drivers or serial loggers.

## Interface
- N, default 8: channel count, N ≥ 2.
- W, default 1: bits per channel, W ≥ 1.
- DWELL, default 4: cycles spent on each channel in scan mode, DWELL ≥ 1.
- SW, derived: $clog2(N), the select width. Not overridable.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  block enable; low forces idle.
- mode  input  1  0 = manual select, 1 = auto-scan.
- s  input  SW  manual channel select; used only when mode = 0.
- a  input  N*W  channel data; channel i occupies a[i*W +: W].
- y  output  W  registered selected channel data.
- ch  output  SW  channel currently presented on y.
- valid  output  1  y/ch hold a legal channel sample.
- wrap  output  1  one-cycle pulse marking the first cycle of a new scan pass.

## Operation
- States: IDLE, MANUAL, SCAN.
  - Any state with en = 0 goes to IDLE.
  - en = 1 and mode = 0 goes to MANUAL.
  - en = 1 and mode = 1 goes to SCAN.
- Each edge computes nxt_ch, then loads ch ← nxt_ch and y ← a[nxt_ch*W +: W] from the a value sampled at that edge. ch, y and valid always agree.
- IDLE:
  - y = 0, ch = 0, valid = 0, wrap = 0.
  - Dwell counter cleared.
- MANUAL:
  - nxt_ch = s, valid = 1.
  - If s ≥ N (only possible when N is not a power of 2): y = 0, ch = s, valid = 0.
- SCAN, entered from IDLE or MANUAL:
  - Starts at ch = 0 with the dwell counter cleared. The entry cycle does not assert wrap.
  - The dwell counter counts 0 .. DWELL-1 on each channel.
  - At count DWELL-1, advance ch to ch+1. From N-1, wrap to 0 and assert wrap for the first cycle at ch = 0.
- Mode change mid-scan:
  - The next edge enters MANUAL and discards scan progress.
  - A later return to SCAN restarts at channel 0.
- en falling mid-operation: the next edge is IDLE, with all outputs at reset values.
- s changes in SCAN and a changes anywhere: a affects y only through the per-edge resample; s is ignored in SCAN.

## Timing
- Reset: asynchronous. State = IDLE; y = 0, ch = 0, valid = 0, wrap = 0, dwell counter = 0. Release is synchronous to the next clk edge.
- Latency: 1 cycle from en/mode/s/a change to the y/ch/valid update.
- A channel in SCAN is held for exactly DWELL cycles. A full pass is N*DWELL cycles, with wrap spaced N*DWELL cycles apart.
- DWELL = 1 steps ch every cycle.
- Simultaneous en = 0 and dwell expiry: IDLE wins, with no wrap pulse.
- All outputs are driven by registers; there are no combinational paths from inputs to outputs.

## Structure
- Package mux_scan_pkg:
  - State enum (IDLE, MANUAL, SCAN).
  - Width helper function used for SW.
- Sub-module scan_timer:
  - Dwell counter with clear, enable and terminal-count output.
  - Parametrised by DWELL; reset shared with the parent.
- The parent holds the FSM, the ch register and the output registers.

## Test plan
- Reset mid-scan (N=8, W=1, DWELL=4, en=1, mode=1, assert rst at ch=5) -> y, ch, valid and wrap are 0 immediately, with no clock edge needed.
- Manual select (N=8, W=4, a=0x76543210, mode=0, s=3) -> one cycle later ch=3, y=0x3, valid=1; s=7 -> y=0x7 the next cycle.
- Scan and wrap (N=4, DWELL=2) -> ch sequence 0,0,1,1,2,2,3,3,0; wrap high only at the second ch=0 entry; no wrap on the initial entry.
- Enable drop (en 1→0 during SCAN at ch=2) -> next edge y=0, ch=0, valid=0; en back to 1 restarts at ch=0.
- Non-power-of-2 select (N=6, mode=0, s=6) -> y=0, valid=0; s=5 -> y=a[5], valid=1.
- Mode switch (scan at ch=2, mode→0, s=1, then mode→1) -> ch goes to 1, then restarts at 0 with a fresh DWELL count.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux_scan selector and its dwell timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum and the width helper used for select/counter widths.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  // Bits needed to index n items; never narrower than 1 so that
  // single-value counters (DWELL = 1) still get a legal vector.
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Dwell counter: counts 0..DWELL-1 while inc is high, then rolls over.
// Latency: tc is combinational from the count register, count updates 1 cycle after inc/clr.
// Backpressure: none; clr has priority over inc.
//
// Ports: clk, rst (async, active-high), clr (sync clear), inc (count enable),
//        tc (count is at DWELL-1, i.e. this is the last cycle on the channel).
module scan_timer
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int            CW   = sel_width(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mux_scan.sv
// Registered N-channel W-bit selector with manual select and auto-scan modes.
// Latency: 1 cycle from en/mode/s/a to y/ch/valid/wrap; all outputs registered.
// Backpressure: none; a new sample is presented every cycle.
//
// Ports: clk, rst (async, active-high); en (low forces idle); mode (0 manual, 1 scan);
//        s (manual select); a (packed channels, channel i at a[i*W +: W]);
//        y (selected data); ch (channel on y); valid (legal sample); wrap (new scan pass).
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int W     = 1,
  parameter  int DWELL = 4,
  localparam int SW    = sel_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic [SW-1:0]   s,
  input  logic [N*W-1:0]  a,
  output logic [W-1:0]    y,
  output logic [SW-1:0]   ch,
  output logic            valid,
  output logic            wrap
);

  localparam logic [SW-1:0] LAST_CH = SW'(N - 1);

  state_t        state;
  logic          scan_run;
  logic          tc;
  logic [SW-1:0] nxt_ch;
  logic          nxt_wrap;
  logic [W-1:0]  nxt_y;
  logic          nxt_legal;

  // Only an already-running scan advances; the entry edge (from IDLE or
  // MANUAL) restarts at channel 0 with a cleared dwell count.
  assign scan_run = en && mode && (state == SCAN);

  scan_timer #(
    .DWELL (DWELL)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (!scan_run),
    .inc (scan_run),
    .tc  (tc)
  );

  always_comb begin
    nxt_ch   = '0;
    nxt_wrap = 1'b0;
    if (en && !mode) begin
      nxt_ch = s;
    end else if (scan_run) begin
      if (!tc) begin
        nxt_ch = ch;
      end else if (ch == LAST_CH) begin
        nxt_ch   = '0;
        nxt_wrap = 1'b1;
      end else begin
        nxt_ch = ch + SW'(1);
      end
    end
  end

  // Select from the current a; a select at or beyond N (non-power-of-2 N)
  // yields zero data and an illegal sample.
  always_comb begin
    nxt_y     = '0;
    nxt_legal = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (nxt_ch == SW'(i)) begin
        nxt_y     = a[i*W +: W];
        nxt_legal = 1'b1;
      end
    end
  end

  // FSM and output registers. en low wins over everything, including a
  // dwell expiry that would otherwise wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ch    <= '0;
      y     <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else if (!en) begin
      state <= IDLE;
      ch    <= '0;
      y     <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= mode ? SCAN : MANUAL;
      ch    <= nxt_ch;
      y     <= nxt_y;
      valid <= nxt_legal;
      wrap  <= nxt_wrap;
    end
  end

endmodule
